uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Round-robin scheduler that shares one serial UART line among N_REQ byte sources.
- Arbitrates pending requests, latches the winning byte and sequences it onto o_tx as a 10-bit frame: start 0, 8 data bits LSB first, stop 1.
- Sits upstream of uart_receiver-style sinks; with CLKS_PER_BIT=1 its frame format matches the receiver's sample-per-clock framing exactly.

Parameters:
N_REQ, 4, number of requesters (legal range 2..16)
CLKS_PER_BIT, 1, clock cycles each serial bit is held (>=1)
GAP_BITS, 1, idle-high bit periods inserted after each stop bit (>=0)

Ports:
i_clk  input  1  clock, all state changes on rising edge
i_rst  input  1  asynchronous reset, active-high
i_req  input  N_REQ  level request per requester; hold until granted
i_data  input  8*N_REQ  byte of requester k on bits [8k+7:8k]; stable while i_req[k]=1
o_gnt  output  N_REQ  one-cycle one-hot pulse: byte of that requester accepted
o_tx  output  1  serial line, idle high
o_busy  output  1  high in any state other than IDLE
o_owner  output  $clog2(N_REQ)  index of the requester whose frame is currently on the line
o_done  output  1  one-cycle pulse after the last stop-bit cycle

Behaviour:
- Reset (async, immediate): state IDLE, o_tx=1, o_gnt=0, o_busy=0, o_owner=0, o_done=0, bit/tick counters 0, RR pointer such that requester 0 has top priority. Reset mid-frame aborts the frame; line returns high with no glitch low.
- States: IDLE, START, DATA, STOP, GAP.
- Arbitration occurs only in IDLE, in the final cycle of STOP when GAP_BITS=0, and in the final cycle of GAP. Winner = first set i_req scanning upward, with wrap, from (last_winner+1) mod N_REQ.
- On the arbitration edge: o_gnt[winner]=1 for exactly that cycle; byte latched into shift register; o_owner=winner; state→START; o_tx=0. The requester may drop i_req or present a new byte from the next cycle.
- Requests are not sampled outside arbitration points. A request withdrawn before grant produces no frame. No grant while o_busy except at back-to-back points.
- Each bit is held CLKS_PER_BIT cycles via a tick counter that wraps at CLKS_PER_BIT-1.
- START (1 bit) → DATA (8 bits, bit0 first; 3-bit counter 0..7) → STOP (o_tx=1, 1 bit) → GAP if GAP_BITS>0 (o_tx=1, GAP_BITS bits) → IDLE, or straight to START if a request is pending at the final GAP/STOP cycle.
- o_done=1 for the single cycle following the last STOP cycle.
- Frame period grant-to-grant, back-to-back: (10+GAP_BITS)*CLKS_PER_BIT cycles.
- o_owner holds its value in IDLE until the next grant.
- Unused i_req bits and out-of-range indices cannot occur: the pointer wraps modulo N_REQ.

Test Plan:
- Reset then i_req=4'b0001, byte0=0xA5 (CLKS_PER_BIT=1, GAP_BITS=1) → o_gnt=0001 for 1 cycle; o_tx from grant edge = 0,1,0,1,0,0,1,0,1,1,1; o_done pulses at cycle 10; o_busy high 11 cycles.
- i_req=4'b1111 held, bytes 0x11,0x22,0x33,0x44 → grant order 0,1,2,3,0; grants exactly 11 cycles apart; o_owner tracks each frame.
- CLKS_PER_BIT=3, GAP_BITS=0, byte 0x80 → start low 3 cycles, seven data zeros for 21 cycles, bit7 high 3 cycles, stop 3 cycles; next grant 30 cycles after first.
- i_rst asserted at cycle 5 of a frame → o_tx=1, o_busy=0, o_gnt=0 immediately; after release, requester 0 wins first and the frame is retransmitted from its start bit.
- i_req[2] pulsed 1 cycle while busy, then dropped → no grant to 2; frame ends; line idles high.
- Loopback into uart_receiver, CLKS_PER_BIT=1, bytes 0x00, 0xFF, 0x5A → receiver o_data equals each byte after its frame.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmit line among N_REQ byte
// sources. A winner is picked only when the line is free (IDLE) or in the
// very last cycle of a frame. Its byte is latched and sent as a 10-bit frame:
// start 0, 8 data bits LSB first, stop 1. GAP_BITS idle-high bit periods
// follow each frame.
module uart_tx_scheduler #(
  parameter int N_REQ        = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter int GAP_BITS     = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [8*N_REQ-1:0]       i_data,
  output logic [N_REQ-1:0]         o_gnt,
  output logic                     o_tx,
  output logic                     o_busy,
  output logic [$clog2(N_REQ)-1:0] o_owner,
  output logic                     o_done
);

  localparam int OWN_W  = $clog2(N_REQ);
  localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GAP_W  = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [OWN_W-1:0]  LAST_IDX = OWN_W'(N_REQ - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

  state_t              state, state_nxt;
  logic [TICK_W-1:0]   tick_cnt;
  logic [2:0]          bit_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [7:0]          shreg;
  logic [OWN_W-1:0]    rr_ptr;
  logic [OWN_W-1:0]    win_idx;
  logic [OWN_W-1:0]    scan_idx;
  logic                win_found;
  logic                tick_last;
  logic                gap_last;
  logic                arb_point;
  logic                grant;

  assign tick_last = (tick_cnt == TICK_MAX);
  assign gap_last  = (gap_cnt == GAP_MAX);
  // The line can be handed over only when free or in the last cycle of a frame.
  assign arb_point = (state == IDLE) ||
                     ((state == STOP) && tick_last && (GAP_BITS == 0)) ||
                     ((state == GAP) && tick_last && gap_last);
  assign grant     = arb_point && win_found;
  assign o_busy    = (state != IDLE);

  // Round-robin search: first pending request at or after rr_ptr, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = OWN_W'((int'(rr_ptr) + i) % N_REQ);
      if (!win_found && i_req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // State register; reset aborts any frame in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state sequencing through the frame, one bit period per tick wrap.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (grant) state_nxt = START;
      START: if (tick_last) state_nxt = DATA;
      DATA:  if (tick_last && (bit_cnt == 3'd7)) state_nxt = STOP;
      STOP: begin
        if (tick_last) begin
          if (GAP_BITS > 0) state_nxt = GAP;
          else if (grant)   state_nxt = START;
          else              state_nxt = IDLE;
        end
      end
      GAP: begin
        if (tick_last && gap_last) state_nxt = grant ? START : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters, grant/done pulses, owner and round-robin pointer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      rr_ptr   <= '0;
      o_owner  <= '0;
      o_gnt    <= '0;
      o_done   <= 1'b0;
    end else begin
      o_gnt  <= '0;
      o_done <= (state == STOP) && tick_last;
      if (state == IDLE || tick_last) tick_cnt <= '0;
      else                            tick_cnt <= tick_cnt + 1'b1;
      if (state == DATA && tick_last) bit_cnt <= bit_cnt + 1'b1;
      if (state == GAP && tick_last)  gap_cnt <= gap_last ? '0 : gap_cnt + 1'b1;
      if (grant) begin
        o_gnt   <= N_REQ'(1) << win_idx;
        o_owner <= win_idx;
        rr_ptr  <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
      end
    end
  end

  // Shift register: load the winning byte, shift right after each data bit.
  always_ff @(posedge i_clk) begin
    if (grant)                      shreg <= i_data[{win_idx, 3'b000} +: 8];
    else if (state == DATA && tick_last) shreg <= {1'b0, shreg[7:1]};
  end

  // Serial line decode: low for start, LSB of shifter for data, high otherwise.
  always_comb begin
    o_tx = 1'b1;
    case (state)
      START:   o_tx = 1'b0;
      DATA:    o_tx = shreg[0];
      default: o_tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: two instances (1 clk/bit with 1 gap bit, and
// 3 clks/bit with no gap), a frame-timeline reference model per instance
// checked every cycle, a sample-per-clock receiver on instance A, and
// directed vectors with literal expectations.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_a = '0, req_b = '0;
  logic [31:0] data_a = '0, data_b = '0;
  logic [3:0]  gnt_a, gnt_b;
  logic        tx_a, tx_b, busy_a, busy_b, done_a, done_b;
  logic [1:0]  owner_a, owner_b;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_scheduler #(.N_REQ(4), .CLKS_PER_BIT(1), .GAP_BITS(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_req(req_a), .i_data(data_a), .o_gnt(gnt_a),
    .o_tx(tx_a), .o_busy(busy_a), .o_owner(owner_a), .o_done(done_a));

  uart_tx_scheduler #(.N_REQ(4), .CLKS_PER_BIT(3), .GAP_BITS(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_req(req_b), .i_data(data_b), .o_gnt(gnt_b),
    .o_tx(tx_b), .o_busy(busy_b), .o_owner(owner_b), .o_done(done_b));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: a frame is a timeline of (10+gap)*cpb cycles from grant.
  logic       m_busy[2];
  int         m_pos[2];
  logic [9:0] m_frame[2];
  int         m_lw[2];
  logic [1:0] m_owner[2];
  logic [3:0] m_gnt[2];
  logic       m_done[2];

  task automatic model_reset(input int u);
    m_busy[u] = 1'b0; m_pos[u] = 0; m_lw[u] = 3; m_owner[u] = '0;
    m_gnt[u] = '0; m_done[u] = 1'b0; m_frame[u] = '1;
  endtask

  task automatic model_step(input int u, input int cpb, input int gap,
                            input logic [3:0] req, input logic [31:0] dat);
    int  len;
    int  k;
    logic arb;
    len = (10 + gap) * cpb;
    arb = !m_busy[u] || (m_pos[u] == len - 1);
    m_done[u] = m_busy[u] && (m_pos[u] == 10 * cpb - 1);
    if (m_busy[u]) begin
      m_pos[u]++;
      if (m_pos[u] == len) m_busy[u] = 1'b0;
    end
    m_gnt[u] = '0;
    if (arb && req != 4'b0) begin
      for (int i = 1; i <= 4; i++) begin
        k = (m_lw[u] + i) % 4;
        if (m_gnt[u] == 4'b0 && req[k]) begin
          m_lw[u] = k; m_owner[u] = 2'(k); m_busy[u] = 1'b1; m_pos[u] = 0;
          m_frame[u] = {1'b1, dat[8*k +: 8], 1'b0};
          m_gnt[u] = 4'(1 << k);
        end
      end
    end
  endtask

  function automatic logic model_tx(input int u, input int cpb);
    if (m_busy[u] && (m_pos[u] / cpb) < 10) return m_frame[u][m_pos[u] / cpb];
    return 1'b1;
  endfunction

  // Receiver on line A, one sample per clock.
  int         rx_st = 0;
  logic [7:0] rx_sh = '0;
  logic [7:0] rxq[$];

  // Compare process: advance models and check both DUTs on every falling edge.
  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(negedge clk);
      if (rst) begin
        model_reset(0); model_reset(1); rx_st = 0;
      end else begin
        model_step(0, 1, 1, req_a, data_a);
        model_step(1, 3, 0, req_b, data_b);
        if (rx_st == 0) begin
          if (tx_a == 1'b0) rx_st = 1;
        end else if (rx_st <= 8) begin
          rx_sh[rx_st-1] = tx_a; rx_st++;
        end else begin
          if (tx_a == 1'b1) rxq.push_back(rx_sh);
          rx_st = 0;
        end
      end
      chk("a_tx",    32'(tx_a),    32'(model_tx(0, 1)));
      chk("a_gnt",   32'(gnt_a),   32'(m_gnt[0]));
      chk("a_busy",  32'(busy_a),  32'(m_busy[0]));
      chk("a_done",  32'(done_a),  32'(m_done[0]));
      chk("a_owner", 32'(owner_a), 32'(m_owner[0]));
      chk("b_tx",    32'(tx_b),    32'(model_tx(1, 3)));
      chk("b_gnt",   32'(gnt_b),   32'(m_gnt[1]));
      chk("b_busy",  32'(busy_b),  32'(m_busy[1]));
      chk("b_done",  32'(done_b),  32'(m_done[1]));
      chk("b_owner", 32'(owner_b), 32'(m_owner[1]));
    end
  end

  task automatic wait_gnt(input int u, input int maxc, output logic ok);
    ok = 1'b0;
    for (int c = 0; c < maxc && !ok; c++) begin
      @(negedge clk);
      if ((u == 0 ? gnt_a : gnt_b) != 4'b0) ok = 1'b1;
    end
    chk("grant_seen", 32'(ok), 32'd1);
  endtask

  task automatic cycles(input int n);
    for (int c = 0; c < n; c++) @(negedge clk);
    #1;
  endtask

  logic        ok;
  logic        seen;
  logic [10:0] lit1;
  logic [9:0]  lit2;
  time         tg[5];
  int          order[5];
  logic [7:0]  bytes[3];

  initial begin
    lit1 = 11'b11101001010;   // 0xA5 frame + gap, index 0 = start bit
    lit2 = 10'b1000011110;    // 0x0F frame, index 0 = start bit
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h5A;

    // Reset state
    cycles(2);
    chk("rst_tx", 32'(tx_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_owner", 32'(owner_a), 32'd0);
    rst = 1'b0;

    // Single frame 0xA5 on A
    req_a = 4'b0001; data_a[7:0] = 8'hA5;
    wait_gnt(0, 5, ok);
    chk("t1_gnt", 32'(gnt_a), 32'h1);
    chk("t1_tx0", 32'(tx_a), 32'd0);
    #1 req_a = 4'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("t1_tx", 32'(tx_a), 32'(lit1[k]));
      chk("t1_done", 32'(done_a), 32'(k == 10));
      chk("t1_busy", 32'(busy_a), 32'd1);
    end
    @(negedge clk);
    chk("t1_idle_busy", 32'(busy_a), 32'd0);
    chk("t1_idle_tx", 32'(tx_a), 32'd1);
    #1;

    // All four requesting after a fresh reset: order 0,1,2,3,0, 11 cycles apart
    rst = 1'b1; cycles(1); rst = 1'b0;
    req_a = 4'b1111; data_a = 32'h44332211;
    for (int g = 0; g < 5; g++) begin
      wait_gnt(0, 15, ok);
      tg[g] = $time;
      chk("t2_gnt", 32'(gnt_a), 32'(1 << order[g]));
      chk("t2_owner", 32'(owner_a), 32'(order[g]));
      if (g > 0) chk("t2_spacing", 32'(tg[g] - tg[g-1]), 32'd110);
    end
    #1 req_a = 4'b0;
    cycles(15);

    // B: 3 clks per bit, no gap, byte 0x80, request held for back-to-back
    req_b = 4'b0001; data_b[7:0] = 8'h80;
    wait_gnt(1, 5, ok);
    chk("t3_tx0", 32'(tx_b), 32'd0);
    for (int c = 1; c < 30; c++) begin
      @(negedge clk);
      chk("t3_tx", 32'(tx_b), 32'(c >= 24));
    end
    @(negedge clk);
    chk("t3_regrant", 32'(gnt_b), 32'h1);
    chk("t3_done", 32'(done_b), 32'd1);
    #1 req_b = 4'b0;
    cycles(35);

    // Reset in the middle of a 0x0F frame on A, then retransmit from start bit
    req_a = 4'b0001; data_a[7:0] = 8'h0F;
    wait_gnt(0, 5, ok);
    for (int c = 0; c < 5; c++) @(negedge clk);
    chk("t4_pre_tx", 32'(tx_a), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("t4_rst_tx", 32'(tx_a), 32'd1);
    chk("t4_rst_busy", 32'(busy_a), 32'd0);
    chk("t4_rst_gnt", 32'(gnt_a), 32'd0);
    cycles(1);
    rst = 1'b0;
    wait_gnt(0, 5, ok);
    chk("t4_gnt", 32'(gnt_a), 32'h1);
    #1 req_a = 4'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("t4_tx", 32'(tx_a), 32'(lit2[k]));
    end
    cycles(5);

    // Request pulsed while busy is never granted
    req_a = 4'b0001; data_a[7:0] = 8'h55;
    wait_gnt(0, 5, ok);
    #1 req_a = 4'b0;
    cycles(2);
    req_a = 4'b0100; data_a[23:16] = 8'h99;
    cycles(1);
    req_a = 4'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (gnt_a != 4'b0) seen = 1'b1;
    end
    chk("t5_no_gnt", 32'(seen), 32'd0);
    chk("t5_tx_idle", 32'(tx_a), 32'd1);
    chk("t5_busy", 32'(busy_a), 32'd0);
    #1;

    // Loopback through the receiver
    rxq.delete();
    for (int b = 0; b < 3; b++) begin
      req_a = 4'b0001; data_a[7:0] = bytes[b];
      wait_gnt(0, 5, ok);
      #1 req_a = 4'b0;
      seen = 1'b0;
      for (int c = 0; c < 15 && !seen; c++) begin
        @(negedge clk);
        if (done_a) seen = 1'b1;
      end
      chk("t6_done_seen", 32'(seen), 32'd1);
      cycles(3);
    end
    chk("t6_rx_count", 32'(rxq.size()), 32'd3);
    for (int b = 0; b < 3; b++)
      if (b < rxq.size()) chk("t6_rx_byte", 32'(rxq[b]), 32'(bytes[b]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
